// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the core's data port. It accepts one access at a time from the
//   M stage, inserts WAIT_STATES busy cycles, and then performs the access: a RAM read or write,
//   a read of the free-running cycle counter, or a write to the LED register.
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   MemEn      access request; held stable with address/data while MemStall=1
//   MemWrite   1 = write, 0 = read
//   ALUResult  byte address (bits [1:0] ignored for RAM)
//   WriteData  store data
//   ReadData   load data, updated at the access edge and held until the next read
//   MemStall   pipeline freeze request
//   Led        LED register
//   AccessErr  sticky flag for accesses that hit neither RAM nor an MMIO register

module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] CNT_ADDR    = 32'hFFFF_FFF0,
    parameter logic [31:0] LED_ADDR    = 32'hFFFF_FFF4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemEn,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemStall,
    output logic [7:0]  Led,
    output logic        AccessErr
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] cyc_q, cyc_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  led_q, led_d;
    logic        err_q, err_d;
    logic        ram_we;
    logic        mem_stall;

    logic [31:0] mem [DEPTH_WORDS];

    // Decode of the latched address. MMIO addresses use a full 32-bit compare so that
    // neighbouring byte addresses fall through to the (out-of-range) RAM decode.
    logic            is_cnt;
    logic            is_led;
    logic            in_ram;
    logic [29:0]     word_idx;
    logic [IdxW-1:0] ram_idx;
    logic            access_now;

    always_comb begin
        is_cnt     = (addr_q == CNT_ADDR);
        is_led     = (addr_q == LED_ADDR);
        word_idx   = addr_q[31:2];
        in_ram     = (32'(word_idx) < DEPTH_WORDS);
        ram_idx    = addr_q[IdxW+1:2];
        access_now = (state_q == StBusy) && (wait_q == 4'd0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (MemEn) state_d = StBusy;
            StBusy:  if (wait_q == 4'd0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: stall follows the request combinationally in idle so the core freezes
    // in the very cycle it presents the access.
    always_comb begin
        mem_stall = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StIdle:  mem_stall = MemEn;
                StBusy:  mem_stall = 1'b1;
                StDone:  mem_stall = 1'b0;
                default: mem_stall = 1'b0;
            endcase
        end
    end

    // Datapath next-state
    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        led_d   = led_q;
        err_d   = err_q;
        cyc_d   = cyc_q + 32'd1;
        ram_we  = 1'b0;

        if ((state_q == StIdle) && MemEn) begin
            we_d    = MemWrite;
            addr_d  = ALUResult;
            wdata_d = WriteData;
            wait_d  = WaitInit;
        end else if ((state_q == StBusy) && (wait_q != 4'd0)) begin
            wait_d = wait_q - 4'd1;
        end else if (access_now) begin
            if (we_q) begin
                if (is_led) begin
                    led_d = wdata_q[7:0];
                end else if (is_cnt) begin
                    led_d = led_q;  // counter is read-only; write silently ignored
                end else if (in_ram) begin
                    ram_we = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                if (is_cnt) begin
                    rdata_d = cyc_q;
                end else if (is_led) begin
                    rdata_d = 32'd0;
                end else if (in_ram) begin
                    rdata_d = mem[ram_idx];
                end else begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wait_q  <= 4'd0;
            cyc_q   <= 32'd0;
            rdata_q <= 32'd0;
            led_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            cyc_q   <= cyc_d;
            rdata_q <= rdata_d;
            led_q   <= led_d;
            err_q   <= err_d;
        end
    end

    // RAM is not reset; a reset landing on the access edge drops the pending write.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            mem[ram_idx] <= wdata_q;
        end
    end

    assign ReadData  = rdata_q;
    assign MemStall  = mem_stall;
    assign Led       = led_q;
    assign AccessErr = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios with literal expectations, a
// randomized phase checked every cycle against a transaction-level model, and a zero-wait
// instance exercised with back-to-back reads.

module tb_dmem_responder;

    localparam int unsigned W        = 2;
    localparam int unsigned DEPTH    = 64;
    localparam logic [31:0] CNT_ADDR = 32'hFFFF_FFF0;
    localparam logic [31:0] LED_ADDR = 32'hFFFF_FFF4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemEn, MemWrite;
    logic [31:0] ALUResult, WriteData, ReadData;
    logic        MemStall, AccessErr;
    logic [7:0]  Led;

    // Zero-wait instance
    logic        e0, w0;
    logic [31:0] a0, d0, rd0;
    logic        st0, err0;
    logic [7:0]  led0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(W),
        .CNT_ADDR   (CNT_ADDR),
        .LED_ADDR   (LED_ADDR)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemEn    (MemEn),
        .MemWrite (MemWrite),
        .ALUResult(ALUResult),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .MemStall (MemStall),
        .Led      (Led),
        .AccessErr(AccessErr)
    );

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(0),
        .CNT_ADDR   (CNT_ADDR),
        .LED_ADDR   (LED_ADDR)
    ) dut0 (
        .clk      (clk),
        .reset    (reset),
        .MemEn    (e0),
        .MemWrite (w0),
        .ALUResult(a0),
        .WriteData(d0),
        .ReadData (rd0),
        .MemStall (st0),
        .Led      (led0),
        .AccessErr(err0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_t: -1 when no access is in flight, else the index of the current cycle counted from
    // the accepting idle cycle (0). Busy cycles are 1..W+1, the access happens at the end of
    // cycle W+1, and cycle W+2 is the single non-stalled completion cycle.
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          m_t;
    bit          m_valid = 1'b0;
    bit          m_we;
    logic [31:0] m_addr, m_data, m_rd, m_cyc;
    bit          m_rd_known;
    logic [7:0]  m_led;
    bit          m_err;

    task automatic model_access();
        if (m_addr == CNT_ADDR) begin
            if (!m_we) begin m_rd = m_cyc; m_rd_known = 1'b1; end
        end else if (m_addr == LED_ADDR) begin
            if (m_we) m_led = m_data[7:0];
            else begin m_rd = 32'd0; m_rd_known = 1'b1; end
        end else if ((m_addr >> 2) < DEPTH) begin
            if (m_we) begin
                m_mem[m_addr>>2]   = m_data;
                m_known[m_addr>>2] = 1'b1;
            end else begin
                m_rd       = m_mem[m_addr>>2];
                m_rd_known = m_known[m_addr>>2];
            end
        end else begin
            m_err = 1'b1;
            if (!m_we) begin m_rd = 32'd0; m_rd_known = 1'b1; end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_t = -1; m_rd = 32'd0; m_rd_known = 1'b1; m_led = 8'd0; m_err = 1'b0;
            m_cyc = 32'd0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_t < 0) begin
                if (MemEn) begin
                    m_we = MemWrite; m_addr = ALUResult; m_data = WriteData; m_t = 1;
                end
            end else begin
                if (m_t == int'(W) + 1) model_access();
                m_t++;
                if (m_t == int'(W) + 3) m_t = -1;
            end
            m_cyc = m_cyc + 32'd1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_valid) begin
            logic exp_stall;
            exp_stall = reset ? 1'b0 : ((m_t < 0) ? MemEn : (m_t <= int'(W) + 1));
            chk("cyc_stall", {31'd0, MemStall}, {31'd0, exp_stall});
            chk("cyc_led", {24'd0, Led}, {24'd0, m_led});
            chk("cyc_err", {31'd0, AccessErr}, {31'd0, m_err});
            if (m_rd_known) chk("cyc_rdata", ReadData, m_rd);
        end
    end

    // ---------------- stimulus ----------------
    // Starts in an idle cycle, returns in the idle cycle after completion.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input bit drop, output int stalls, output logic [31:0] rd);
        bit done;
        done      = 1'b0;
        stalls    = 0;
        MemEn     = 1'b1;
        MemWrite  = we;
        ALUResult = a;
        WriteData = d;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!MemStall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            // Drop the request after acceptance; the latched values must still be used.
            if (drop && i == 1) begin
                MemEn = 1'b0; MemWrite = ~MemWrite;
                ALUResult = $urandom; WriteData = $urandom;
            end
        end
        rd = ReadData;
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL access_timeout: MemStall still %b, expected 0 within 16 cycles", MemStall);
        end
        @(posedge clk); #1;
        MemEn = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1; MemEn = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int          st;
        logic [31:0] rd, r1, r2;
        reset = 1'b1; MemEn = 1'b1; MemWrite = 1'b0; ALUResult = 32'h10; WriteData = 32'd0;
        e0 = 1'b0; w0 = 1'b0; a0 = 32'd0; d0 = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", {31'd0, MemStall}, 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_led", {24'd0, Led}, 32'd0);
        chk("rst_err", {31'd0, AccessErr}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; MemEn = 1'b0;

        // Basic write/read with wait states
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, st, rd);
        chk("wr10_stall", st, 32'd4);
        access(1'b0, 32'h10, 32'd0, 1'b0, st, rd);
        chk("rd10_stall", st, 32'd4);
        chk("rd10_data", rd, 32'hDEAD_BEEF);

        // Out-of-range read, sticky error
        access(1'b0, 32'h0000_0400, 32'd0, 1'b0, st, rd);
        chk("miss_rdata", rd, 32'd0);
        chk("miss_err", {31'd0, AccessErr}, 32'd1);
        access(1'b1, 32'h14, 32'h55, 1'b0, st, rd);
        access(1'b0, 32'h14, 32'd0, 1'b0, st, rd);
        chk("err_sticky", {31'd0, AccessErr}, 32'd1);
        chk("rd14_data", rd, 32'h55);
        pulse_reset();
        chk("err_cleared", {31'd0, AccessErr}, 32'd0);

        // LED register
        access(1'b1, LED_ADDR, 32'h1234_56A5, 1'b0, st, rd);
        chk("led_val", {24'd0, Led}, 32'hA5);
        access(1'b0, LED_ADDR, 32'd0, 1'b0, st, rd);
        chk("led_rd", rd, 32'd0);
        chk("led_err", {31'd0, AccessErr}, 32'd0);

        // Back-to-back counter reads: one idle, W+1 busy and one done cycle apart (= 5)
        access(1'b0, CNT_ADDR, 32'd0, 1'b0, st, r1);
        access(1'b0, CNT_ADDR, 32'd0, 1'b0, st, r2);
        chk("cnt_delta", r2 - r1, 32'd5);
        access(1'b1, CNT_ADDR, 32'hFFFF_FFFF, 1'b0, st, rd);
        chk("cnt_wr_noerr", {31'd0, AccessErr}, 32'd0);

        // Reset on the access edge of a write aborts it
        access(1'b1, 32'h20, 32'h1, 1'b0, st, rd);
        MemEn = 1'b1; MemWrite = 1'b1; ALUResult = 32'h20; WriteData = 32'h2;
        repeat (3) begin @(posedge clk); #1; end  // now in the last busy cycle
        reset = 1'b1;
        @(negedge clk);
        chk("abort_stall", {31'd0, MemStall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; MemEn = 1'b0;
        chk("abort_led", {24'd0, Led}, 32'd0);
        chk("abort_rdata", ReadData, 32'd0);
        access(1'b0, 32'h20, 32'd0, 1'b0, st, rd);
        chk("abort_rd20", rd, 32'h1);

        // Randomized phase
        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            if (kind <= 5) a = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
            else if (kind == 6) a = CNT_ADDR;
            else if (kind == 7) a = LED_ADDR;
            else if (kind == 8) a = 32'h0000_0100 | $urandom;
            else a = ($urandom_range(0, 1) ? CNT_ADDR : LED_ADDR) + $urandom_range(1, 3);
            if (kind == 8 && (a == CNT_ADDR || a == LED_ADDR)) a = 32'h0000_0100;
            access(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 7) == 0), st, rd);
            chk("rand_stall", st, W + 2);
            if ($urandom_range(0, 39) == 0) pulse_reset();
            repeat ($urandom_range(0, 2)) begin
                MemWrite = 1'($urandom); ALUResult = $urandom; WriteData = $urandom;
                @(posedge clk); #1;
            end
        end

        // Zero-wait instance: MemEn held high, four writes then four reads, period 3
        e0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w0 = (i < 4);
            a0 = 32'((i % 4) * 4);
            d0 = 32'h1000_0000 + 32'(i);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("w0_stall", {31'd0, st0}, (k != 2) ? 32'd1 : 32'd0);
                if (k == 2 && i >= 4) chk("w0_rdata", rd0, 32'h1000_0000 + 32'(i - 4));
                @(posedge clk); #1;
            end
        end
        e0 = 1'b0;
        @(negedge clk);
        chk("w0_err", {31'd0, err0}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
